// File: rtl/guitar_pkg.sv
// Shared types and timing defaults for the guitar input conditioner.
// Holds the per-player FSM state encoding and counter-width helper.
package guitar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HIT     = 2'd1,
        ST_LOCKOUT = 2'd2
    } player_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_LOCKOUT_CYCLES  = 5000000;
    localparam int NUM_PLAYERS             = 2;
    localparam int NUM_FRETS               = 3;

    // Bits needed to count 0..cycles-1, never less than one.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One raw input: 2-flop synchronizer followed by a counting debouncer.
// The accepted value only moves after DEBOUNCE_CYCLES consecutive differing samples.
module input_debounce
    import guitar_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;

    // Metastability synchronizer for the asynchronous raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RESET_VALUE;
            sync2_r <= RESET_VALUE;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter: any sample matching the stable value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= RESET_VALUE;
            cnt_r    <= '0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= sync2_r;
            cnt_r    <= '0;
        end else begin
            cnt_r    <= cnt_r + 1'b1;
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/guitar_input_conditioner.sv
// Conditions two guitar controllers: debounces frets and strum bars, then
// runs a per-player strum FSM producing hit/miss strobes with a lockout window.
module guitar_input_conditioner
    import guitar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [2:0] p1_btn_n,
    input  logic       p1_strum,
    input  logic [2:0] p2_btn_n,
    input  logic       p2_strum,
    output logic [5:0] guitar_in,
    output logic [5:0] hit_pulse,
    output logic [1:0] miss_pulse,
    output logic [1:0] busy
);

    localparam int            LW        = cnt_width(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    // Buttons idle high (released), strum bars idle low.
    localparam logic [7:0]    RST_VEC   = 8'b0111_0111;

    logic [7:0] raw_s;
    logic [7:0] stable_s;

    assign raw_s = {p2_strum, p2_btn_n, p1_strum, p1_btn_n};

    for (genvar i = 0; i < 8; i++) begin : g_deb
        input_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RST_VEC[i])
        ) u_deb (
            .clk    (CLOCK_50),
            .rst_n  (resetn),
            .raw    (raw_s[i]),
            .stable (stable_s[i])
        );
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [NUM_FRETS-1:0] frets_s;
        logic                 strum_s;
        logic                 strum_edge_s;
        player_state_t        state_r;
        player_state_t        state_nx;
        logic [LW-1:0]        lock_cnt_r;
        logic [LW-1:0]        lock_cnt_nx;
        logic                 strum_prev_r;
        logic [NUM_FRETS-1:0] hit_r;
        logic [NUM_FRETS-1:0] hit_nx;
        logic                 miss_r;
        logic                 miss_nx;

        assign frets_s      = ~stable_s[p*4 +: NUM_FRETS];
        assign strum_s      = stable_s[p*4 + 3];
        assign strum_edge_s = strum_s & ~strum_prev_r;

        // Strum FSM state, lockout counter and registered strobes.
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                state_r      <= ST_IDLE;
                lock_cnt_r   <= '0;
                strum_prev_r <= 1'b0;
                hit_r        <= '0;
                miss_r       <= 1'b0;
            end else begin
                state_r      <= state_nx;
                lock_cnt_r   <= lock_cnt_nx;
                strum_prev_r <= strum_s;
                hit_r        <= hit_nx;
                miss_r       <= miss_nx;
            end
        end

        // Next-state logic; strobes are captured on the IDLE->HIT transition.
        always_comb begin
            state_nx    = state_r;
            lock_cnt_nx = lock_cnt_r;
            hit_nx      = '0;
            miss_nx     = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (strum_edge_s) begin
                        state_nx = ST_HIT;
                        hit_nx   = frets_s;
                        miss_nx  = (frets_s == 3'b000);
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_HIT: begin
                    state_nx    = ST_LOCKOUT;
                    lock_cnt_nx = '0;
                end
                ST_LOCKOUT: begin
                    // Counter saturates; exit only once the strum bar is released.
                    if (lock_cnt_r == LOCK_LAST) begin
                        if (!strum_s) begin
                            state_nx = ST_IDLE;
                        end else begin
                            state_nx = ST_LOCKOUT;
                        end
                    end else begin
                        lock_cnt_nx = lock_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_nx    = ST_IDLE;
                    lock_cnt_nx = '0;
                end
            endcase
        end

        assign guitar_in[p*NUM_FRETS +: NUM_FRETS] = frets_s & {NUM_FRETS{strum_s}};
        assign hit_pulse[p*NUM_FRETS +: NUM_FRETS] = hit_r;
        assign miss_pulse[p]                       = miss_r;
        assign busy[p]                             = (state_r == ST_LOCKOUT);
    end

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Directed bench for guitar_input_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_guitar_input_conditioner;

    localparam int DEB  = 4;
    localparam int LOCK = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] p1_btn_n;
    logic       p1_strum;
    logic [2:0] p2_btn_n;
    logic       p2_strum;
    logic [5:0] guitar_in;
    logic [5:0] hit_pulse;
    logic [1:0] miss_pulse;
    logic [1:0] busy;

    always #5 clk = ~clk;

    guitar_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCK)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .p1_btn_n   (p1_btn_n),
        .p1_strum   (p1_strum),
        .p2_btn_n   (p2_btn_n),
        .p2_strum   (p2_strum),
        .guitar_in  (guitar_in),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .busy       (busy)
    );

    typedef struct {
        string      name;
        logic [2:0] p1_btn_n;
        logic       p1_strum;
        logic [2:0] p2_btn_n;
        logic       p2_strum;
        int         wait_cycles;
        logic [5:0] exp_gi;
        logic [5:0] exp_hit;
        logic [1:0] exp_miss;
        logic [1:0] exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [5:0] gi, input logic [5:0] hit,
                                 input logic [1:0] miss, input logic [1:0] bsy);
        check({tag, "_gi"},   32'(guitar_in),  32'(gi));
        check({tag, "_hit"},  32'(hit_pulse),  32'(hit));
        check({tag, "_miss"}, 32'(miss_pulse), 32'(miss));
        check({tag, "_busy"}, 32'(busy),       32'(bsy));
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] b1, input logic s1,
                                input logic [2:0] b2, input logic s2, input int w,
                                input logic [5:0] gi, input logic [5:0] hit,
                                input logic [1:0] miss, input logic [1:0] bsy);
        vec_t v;
        v.name = n; v.p1_btn_n = b1; v.p1_strum = s1; v.p2_btn_n = b2; v.p2_strum = s2;
        v.wait_cycles = w; v.exp_gi = gi; v.exp_hit = hit; v.exp_miss = miss; v.exp_busy = bsy;
        return v;
    endfunction

    initial begin
        int         hits;
        int         misses;
        int         first;
        logic [5:0] hit_val;

        // Steady-state timeline: each row is applied, held for wait_cycles, then checked.
        vecs.push_back(mk("idle",         3'b111, 1'b0, 3'b111, 1'b0, 2, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("p1_fret",      3'b110, 1'b0, 3'b111, 1'b0, 8, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("p1_gi",        3'b110, 1'b1, 3'b111, 1'b0, 6, 6'b000001, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("p1_hit",       3'b110, 1'b1, 3'b111, 1'b0, 1, 6'b000001, 6'b000001, 2'b00, 2'b00));
        vecs.push_back(mk("p1_lock",      3'b110, 1'b1, 3'b111, 1'b0, 1, 6'b000001, 6'b000000, 2'b00, 2'b01));
        vecs.push_back(mk("p1_rel",       3'b110, 1'b0, 3'b111, 1'b0, 7, 6'b000000, 6'b000000, 2'b00, 2'b01));
        vecs.push_back(mk("p1_idle",      3'b110, 1'b0, 3'b111, 1'b0, 1, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("p2_glitch",    3'b110, 1'b0, 3'b111, 1'b1, 3, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("p2_reject",    3'b110, 1'b0, 3'b111, 1'b0, 10, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("p1_open",      3'b111, 1'b0, 3'b111, 1'b0, 8, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("miss_wait",    3'b111, 1'b1, 3'b111, 1'b0, 6, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("miss",         3'b111, 1'b1, 3'b111, 1'b0, 1, 6'b000000, 6'b000000, 2'b01, 2'b00));
        vecs.push_back(mk("miss_lock",    3'b111, 1'b1, 3'b111, 1'b0, 1, 6'b000000, 6'b000000, 2'b00, 2'b01));
        vecs.push_back(mk("miss_hold",    3'b111, 1'b1, 3'b111, 1'b0, 7, 6'b000000, 6'b000000, 2'b00, 2'b01));
        vecs.push_back(mk("miss_rel",     3'b111, 1'b0, 3'b111, 1'b0, 6, 6'b000000, 6'b000000, 2'b00, 2'b01));
        vecs.push_back(mk("miss_idle",    3'b111, 1'b0, 3'b111, 1'b0, 1, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("dual_fret",    3'b100, 1'b0, 3'b011, 1'b0, 8, 6'b000000, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("dual_gi",      3'b100, 1'b1, 3'b011, 1'b1, 6, 6'b100011, 6'b000000, 2'b00, 2'b00));
        vecs.push_back(mk("dual_hit",     3'b100, 1'b1, 3'b011, 1'b1, 1, 6'b100011, 6'b100011, 2'b00, 2'b00));
        vecs.push_back(mk("dual_lock",    3'b100, 1'b1, 3'b011, 1'b1, 1, 6'b100011, 6'b000000, 2'b00, 2'b11));
        vecs.push_back(mk("dual_rel",     3'b100, 1'b0, 3'b011, 1'b0, 7, 6'b000000, 6'b000000, 2'b00, 2'b11));
        vecs.push_back(mk("dual_idle",    3'b100, 1'b0, 3'b011, 1'b0, 1, 6'b000000, 6'b000000, 2'b00, 2'b00));

        resetn   = 1'b0;
        p1_btn_n = 3'b111;
        p1_strum = 1'b0;
        p2_btn_n = 3'b111;
        p2_strum = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset", 6'b000000, 6'b000000, 2'b00, 2'b00);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            p1_btn_n = vecs[i].p1_btn_n;
            p1_strum = vecs[i].p1_strum;
            p2_btn_n = vecs[i].p2_btn_n;
            p2_strum = vecs[i].p2_strum;
            repeat (vecs[i].wait_cycles) @(negedge clk);
            check_outputs(vecs[i].name, vecs[i].exp_gi, vecs[i].exp_hit,
                          vecs[i].exp_miss, vecs[i].exp_busy);
        end

        // Re-strum inside the lockout window must be discarded.
        p1_btn_n = 3'b110;
        p2_btn_n = 3'b111;
        repeat (8) @(negedge clk);
        p1_strum = 1'b1;
        hits = 0; misses = 0; first = -1; hit_val = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (hit_pulse != 6'b000000) begin
                hits++;
                if (first < 0) begin
                    first   = c;
                    hit_val = hit_pulse;
                end
            end
            if (miss_pulse != 2'b00) misses++;
            if (c == 4)  p1_strum = 1'b0;
            if (c == 8)  p1_strum = 1'b1;
            if (c == 12) p1_btn_n = 3'b101;
        end
        check("reedge_hits",   hits,   1);
        check("reedge_first",  first,  7);
        check("reedge_value",  32'(hit_val), 32'(6'b000001));
        check("reedge_misses", misses, 0);
        check("reedge_busy",   32'(busy), 32'(2'b01));

        p1_strum = 1'b0;
        hits = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (hit_pulse != 6'b000000) hits++;
        end
        check("release_hits", hits, 0);
        check("release_busy", 32'(busy), 32'(2'b00));

        p1_strum = 1'b1;
        repeat (7) @(negedge clk);
        check("restrum_hit", 32'(hit_pulse), 32'(6'b000010));
        repeat (3) @(negedge clk);
        check("restrum_busy", 32'(busy), 32'(2'b01));

        // Asynchronous reset during lockout with the strum bar still held.
        #2 resetn = 1'b0;
        #1;
        check_outputs("async_rst", 6'b000000, 6'b000000, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        hits = 0; first = -1; hit_val = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (hit_pulse != 6'b000000) begin
                hits++;
                if (first < 0) begin
                    first   = c;
                    hit_val = hit_pulse;
                end
            end
        end
        check("post_rst_hits",  hits,  1);
        check("post_rst_first", first, 7);
        check("post_rst_value", 32'(hit_val), 32'(6'b000010));
        check("post_rst_busy",  32'(busy), 32'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
